// File: rtl/uart_tx_serializer.sv
// Purpose : 16550-style UART transmit shift engine (start, 5-8 data bits LSB first,
//           optional odd/even/stick parity, 1/1.5/2 stop bits), clocked by a 16x baud tick.
// Latency : TXD follows the framing state one CLK later; TXDONE pulses after the last stop tick.
// Backpressure: DIN_READY is high only in IDLE with CLEAR low; a character is taken on DIN_VALID & DIN_READY.
// Optional feature: define UART_TX_BREAK_EN to let BC force TXD low (break) without disturbing framing.
module uart_tx_serializer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TXTICK,
  input  logic       CLEAR,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic       TXD,
  output logic       BUSY,
  output logic       TXDONE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] tick_q, tick_d;           // 16x tick count within the current bit
  logic [2:0] bit_q, bit_d;             // index of the data bit being sent
  logic [7:0] shift_q, shift_d;         // data shifter, bit 0 is on the line
  logic [2:0] last_bit_q, last_bit_d;   // index of the final data bit (4..7)
  logic       pen_q, pen_d;
  logic       par_q, par_d;             // parity value, fixed at acceptance
  logic [4:0] stop_last_q, stop_last_d; // final tick index of the stop period (15/23/31)
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       txdone_q, txdone_d;

  logic [7:0] din_mask;
  logic       accept;
  logic       bit_end;
  logic       stop_end;

  assign DIN_READY = (state_q == S_IDLE) & ~CLEAR;
  assign accept    = DIN_VALID & DIN_READY;
  assign bit_end   = TXTICK & (tick_q == 5'd15);
  assign stop_end  = TXTICK & (tick_q == stop_last_q);

  assign TXD    = txd_q;
  assign BUSY   = busy_q;
  assign TXDONE = txdone_q;

  // Keep only the bits inside the selected word length for parity generation.
  always_comb begin
    din_mask = DIN;
    case (WLS)
      2'b00:   din_mask = DIN & 8'h1F;
      2'b01:   din_mask = DIN & 8'h3F;
      2'b10:   din_mask = DIN & 8'h7F;
      default: din_mask = DIN;
    endcase
  end

  // Framing FSM: next state, tick/bit counters, shifter and registered line outputs.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    last_bit_d  = last_bit_q;
    pen_d       = pen_q;
    par_d       = par_q;
    stop_last_d = stop_last_q;
    txdone_d    = 1'b0;
    txd_d       = 1'b1;

    if (TXTICK) begin
      tick_d = tick_q + 5'd1;
    end

    case (state_q)
      S_IDLE: begin
        // A tick on the accepting edge must not count toward the start bit.
        tick_d = 5'd0;
        bit_d  = 3'd0;
        if (accept) begin
          state_d     = S_START;
          shift_d     = DIN;
          last_bit_d  = {1'b1, WLS};
          pen_d       = PEN;
          par_d       = SP ? ~EPS : ((^din_mask) ^ ~EPS);
          stop_last_d = ~STB ? 5'd15 : ((WLS == 2'b00) ? 5'd23 : 5'd31);
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tick_d  = 5'd0;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          tick_d  = 5'd0;
          shift_d = shift_q >> 1;
          if (bit_q == last_bit_q) begin
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tick_d  = 5'd0;
        end
      end
      S_STOP: begin
        if (stop_end) begin
          state_d  = S_IDLE;
          tick_d   = 5'd0;
          txdone_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = 5'd0;
      end
    endcase

    // Line level reflects the state being left at this edge, hence one CLK behind it.
    case (state_q)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_q[0];
      S_PARITY: txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase

    // Abort wins over everything except reset; no completion pulse on abort.
    if (CLEAR) begin
      state_d  = S_IDLE;
      tick_d   = 5'd0;
      bit_d    = 3'd0;
      txdone_d = 1'b0;
      txd_d    = 1'b1;
    end

`ifdef UART_TX_BREAK_EN
    // Break only overrides the pin; counters keep running so frame timing is intact.
    if (BC) begin
      txd_d = 1'b0;
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with asynchronous reset to the idle line condition.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      tick_q      <= 5'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      last_bit_q  <= 3'd7;
      pen_q       <= 1'b0;
      par_q       <= 1'b0;
      stop_last_q <= 5'd15;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      txdone_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      last_bit_q  <= last_bit_d;
      pen_q       <= pen_d;
      par_q       <= par_d;
      stop_last_q <= stop_last_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      txdone_q    <= txdone_d;
    end
  end

`ifndef UART_TX_BREAK_EN
  // Break control has no effect in this build; the port is kept for compatibility.
  logic unused_bc;
  assign unused_bc = BC;
`endif

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit shift engine of the APB UART. It consumes the 16x-oversampled baud tick from the baud generator and serialises one character per handshake onto TXD. Framing follows 16550 LCR semantics: 5–8 data bits LSB first, optional parity (odd, even or stick), and 1, 1.5 or 2 stop bits. It sits between the transmit FIFO/holding register and the TXD pad.

## Interface
- No parameters; widths fixed by 16550 register map.
- CLK  in  1  system clock, one clock domain.
- RST  in  1  asynchronous, active-high reset.
- TXTICK  in  1  16x baud tick from baud generator; one-CLK pulse.
- CLEAR  in  1  synchronous abort; highest priority after RST.
- WLS  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
- STB  in  1  0: 1 stop bit; 1: 1.5 stop bits if WLS=00, else 2.
- PEN  in  1  parity enable.
- EPS  in  1  even parity select.
- SP  in  1  stick parity.
- BC  in  1  break control (see Configuration).
- DIN  in  8  character; bits above word length ignored.
- DIN_VALID  in  1  character available.
- DIN_READY  out  1  engine can accept a character.
- TXD  out  1  serial output, idle high.
- BUSY  out  1  shift register not empty (frame in progress).
- TXDONE  out  1  one-CLK pulse at end of last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TXD=1, DIN_READY=1, BUSY=0. Transfer occurs on a CLK edge with DIN_VALID & DIN_READY. DIN, WLS, STB, PEN, EPS and SP are latched at this edge. Changes to these inputs mid-frame have no effect.
- Next state after the transfer is START. DIN_READY drops and BUSY rises on the same edge.
- Tick counter: 4 bits for data, start and parity bits; 5 bits for stop. Increments on TXTICK only. A bit ends when the counter reaches 15 (16 ticks) and TXTICK is high.
- START: TXD=0 for 16 ticks, then DATA.
- DATA: shifts LSB first, 16 ticks per bit, for the latched word length.
  - After the last bit: PARITY if PEN=1, else STOP.
- PARITY bit value:
  - SP=0: XOR of the data bits, inverted when EPS=0 (odd parity).
  - SP=1: the value is ~EPS.
- STOP: TXD=1 for 16, 24 or 32 ticks per the latched STB/WLS. At the end, pulse TXDONE and return to IDLE.
  - In that cycle DIN_READY=1 again, so back-to-back frames have no idle gap beyond one CLK.
- CLEAR=1 in any state: go to IDLE, TXD=1, counters zeroed, TXDONE not pulsed. A handshake in the same cycle as CLEAR is not accepted: DIN_READY is forced 0 while CLEAR=1.
- TXTICK coincident with the handshake edge is not counted toward the start bit.

## Timing
- Reset values: TXD=1, DIN_READY=1, BUSY=0, TXDONE=0, state=IDLE.
- TXD, BUSY and TXDONE are registered. DIN_READY = (state==IDLE) & ~CLEAR.
- TXD falls one CLK after the accepting edge.
- Frame length in ticks = 16 × (1 + wordlen + PEN) + stop ticks (16/24/32).
- RST mid-frame: immediate return to reset values. The frame is truncated and no TXDONE is produced.

## Configuration
- Macro UART_TX_BREAK_EN.
- Defined:
  - BC=1 forces TXD=0 regardless of state. Framing continues internally, so timing is unaffected.
  - Releasing BC restores normal TXD on the next CLK.
- Undefined: BC is ignored. The port remains for interface compatibility.

## Test plan
- TXTICK every 4 CLK; WLS=11, PEN=0, STB=0; DIN=0x55. Required: TXD sequence 0,1,0,1,0,1,0,1,0,1, each level 16 ticks; TXDONE at tick 160; DIN_READY high in that same cycle.
- WLS=00, STB=1, PEN=1, EPS=1, SP=0; DIN=0xF3 (data 10011). Required: start, 1,1,0,0,1, parity=1, 24-tick stop; total 136 ticks.
- PEN=1, SP=1, EPS=0, WLS=10, DIN=0x00. Required: parity bit=1; 2 stop bits (32 ticks).
- Back-to-back: DIN_VALID held high with 0xA5 then 0x3C. Required: second start bit begins one CLK after the first TXDONE; no extra idle ticks.
- CLEAR asserted at tick 50 of a frame, with DIN_VALID high. Required: TXD=1 the next CLK, no TXDONE, DIN_READY=0 while CLEAR=1. A new frame starts cleanly after CLEAR drops.
- RST asserted mid-DATA: TXD=1 and BUSY=0 immediately. With UART_TX_BREAK_EN defined, BC=1 during IDLE gives TXD=0. Without it, TXD stays 1.
